seq_step_tracker: RTL and testbench



---
 rtl/seq_step_tracker.sv | 90 +++++++++
 tb/tb_seq_step_tracker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_step_tracker.sv
// seq_step_tracker: counts runs of consecutive advance events and reports
// progress as a thermometer code (S), a binary level and a done pulse.
// All outputs come straight from registers; enter/clear only reach them
// through a clock edge.
module seq_step_tracker #(
  parameter int STEPS     = 3,
  parameter int GAP_MAX   = 0,
  parameter int TOP_MODE  = 0,
  parameter int EDGE_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enter,
  input  logic                       clear,
  output logic [STEPS-1:0]           S,
  output logic [$clog2(STEPS+1)-1:0] level,
  output logic                       done
);

  localparam int LW = $clog2(STEPS + 1);
  localparam int IW = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
  localparam logic [LW-1:0] TOP = LW'(STEPS);
  localparam logic [IW-1:0] GAP = IW'(GAP_MAX);

  logic [LW-1:0] lvl_reg, lvl_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic          enter_d_reg;
  logic          done_reg, done_next;
  logic          ev;
  logic          at_top;

  // Event qualification: level mode takes enter as-is, edge mode needs 0->1.
  assign ev     = (EDGE_MODE != 0) ? (enter & ~enter_d_reg) : enter;
  assign at_top = (lvl_reg == TOP);

  // State register: level, idle counter, edge-detect history and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_reg     <= '0;
      idle_reg    <= '0;
      enter_d_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      lvl_reg     <= lvl_next;
      idle_reg    <= idle_next;
      enter_d_reg <= enter;
      done_reg    <= done_next;
    end
  end

  // Next-state rules in priority order; clear beats everything, a wrap-mode
  // top always falls back to zero, then events advance, then idle handling.
  always_comb begin
    lvl_next  = lvl_reg;
    idle_next = idle_reg;
    if (clear) begin
      lvl_next  = '0;
      idle_next = '0;
    end else if (at_top && (TOP_MODE == 0)) begin
      lvl_next  = '0;
      idle_next = '0;
    end else if (ev && !at_top) begin
      lvl_next  = lvl_reg + LW'(1);
      idle_next = '0;
    end else if (ev) begin
      idle_next = '0;
    end else if (lvl_reg == '0) begin
      idle_next = '0;
    end else if (idle_reg == GAP) begin
      lvl_next  = '0;
      idle_next = '0;
    end else begin
      idle_next = idle_reg + IW'(1);
    end
    // Pulse only on arrival at top, never while sitting there.
    done_next = (lvl_next == TOP) && !at_top;
  end

  // Thermometer decode: bit i lit once the level has passed step i.
  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_therm
      localparam logic [LW-1:0] IDX = LW'(gi);
      assign S[gi] = (lvl_reg > IDX);
    end
  endgenerate

  assign level = lvl_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_seq_step_tracker.sv
// Scoreboard bench for seq_step_tracker: four parameter sets side by side.
// Stimulus pushes the hand-computed response for the next clock into a queue;
// the monitor pops and compares one clock edge later.
module tb_seq_step_tracker;

  logic clk;
  logic reset;
  logic e0, e1, e2, e3;
  logic c0, c1, c2, c3;
  logic [2:0] s0, s1, s3;
  logic [3:0] s2;
  logic [1:0] l0, l1, l3;
  logic [2:0] l2;
  logic d0, d1, d2, d3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int    cyc;
    int    dut;
    int    lvl;
    bit    dn;
    string name;
  } exp_t;

  exp_t q[$];

  // d0: defaults
  seq_step_tracker u0 (.clk(clk), .reset(reset), .enter(e0), .clear(c0),
                       .S(s0), .level(l0), .done(d0));
  // d1: idle-gap tolerance of 2
  seq_step_tracker #(.GAP_MAX(2)) u1 (.clk(clk), .reset(reset), .enter(e1),
                       .clear(c1), .S(s1), .level(l1), .done(d1));
  // d2: four steps, saturate at top
  seq_step_tracker #(.STEPS(4), .TOP_MODE(1)) u2 (.clk(clk), .reset(reset),
                       .enter(e2), .clear(c2), .S(s2), .level(l2), .done(d2));
  // d3: edge qualified, gap tolerance of 3
  seq_step_tracker #(.EDGE_MODE(1), .GAP_MAX(3)) u3 (.clk(clk), .reset(reset),
                       .enter(e3), .clear(c3), .S(s3), .level(l3), .done(d3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input exp_t e);
    int al, as_, es;
    bit ad;
    case (e.dut)
      0: begin al = int'(l0); as_ = int'(s0); ad = d0; end
      1: begin al = int'(l1); as_ = int'(s1); ad = d1; end
      2: begin al = int'(l2); as_ = int'(s2); ad = d2; end
      default: begin al = int'(l3); as_ = int'(s3); ad = d3; end
    endcase
    es = (1 << e.lvl) - 1;
    checks++;
    if (al != e.lvl || as_ != es || ad != e.dn) begin
      errors++;
      $display("FAIL %s dut%0d: got level=%0d S=%b done=%b, want level=%0d S=%b done=%b",
               e.name, e.dut, al, as_[3:0], ad, e.lvl, es[3:0], e.dn);
    end else begin
      $display("ok   %s dut%0d cyc%0d level=%0d S=%b done=%b",
               e.name, e.dut, e.cyc, al, as_[3:0], ad);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare whatever is due now.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d: expectation for cycle %0d never compared (now %0d)",
                 e.name, e.dut, e.cyc, cyc);
      end else begin
        compare(e);
      end
    end
  end

  // Drive one cycle of stimulus on one DUT and record its expected response.
  task automatic step(input int dut, input bit en, input bit cl,
                      input int lvl, input bit dn, input string name);
    exp_t e;
    case (dut)
      0: begin e0 = en; c0 = cl; end
      1: begin e1 = en; c1 = cl; end
      2: begin e2 = en; c2 = cl; end
      default: begin e3 = en; c3 = cl; end
    endcase
    e.cyc  = cyc + 1;
    e.dut  = dut;
    e.lvl  = lvl;
    e.dn   = dn;
    e.name = name;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Hard time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int lv1[6]  = '{1, 2, 3, 0, 1, 2};
    bit dn1[6]  = '{0, 0, 1, 0, 0, 0};
    bit en2[4]  = '{1, 1, 0, 1};
    int lv2[4]  = '{1, 2, 0, 1};
    bit en3[7]  = '{1, 0, 0, 1, 0, 0, 0};
    int lv3[7]  = '{1, 1, 1, 2, 2, 2, 0};
    int lv4[7]  = '{1, 2, 3, 4, 4, 4, 4};
    bit dn4[7]  = '{0, 0, 0, 1, 0, 0, 0};
    bit en5[12] = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0};
    int lv5[12] = '{1, 1, 1, 1, 0, 0, 1, 1, 2, 2, 3, 0};
    bit dn5[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    reset = 1'b1;
    {e0, e1, e2, e3} = '0;
    {c0, c1, c2, c3} = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state on every instance
    for (int d = 0; d < 4; d++) begin
      exp_t e;
      e.cyc = cyc + 1; e.dut = d; e.lvl = 0; e.dn = 0; e.name = "reset_state";
      q.push_back(e);
    end
    @(negedge clk);

    // 1: defaults, enter held high, wraps after top
    for (int i = 0; i < 6; i++) step(0, 1, 0, lv1[i], dn1[i], "wrap_run");
    step(0, 0, 0, 0, 0, "wrap_idle_drop");

    // 2: defaults, an idle cycle breaks the run
    for (int i = 0; i < 4; i++) step(0, en2[i], 0, lv2[i], 0, "gap_break");
    step(0, 0, 0, 0, 0, "gap_break_idle");

    // 3: GAP_MAX=2 tolerates two idle cycles, third clears
    for (int i = 0; i < 7; i++) step(1, en3[i], 0, lv3[i], 0, "gap_tol");

    // 4: STEPS=4 saturating, done once, idle drops to 0
    for (int i = 0; i < 7; i++) step(2, 1, 0, lv4[i], dn4[i], "saturate");
    step(2, 0, 0, 0, 0, "saturate_idle");

    // 5: edge mode: held enter counts once, then pulses climb to top
    for (int i = 0; i < 12; i++) step(3, en5[i], 0, lv5[i], dn5[i], "edge_mode");

    // 6a: asynchronous reset mid-run
    step(0, 1, 0, 1, 0, "pre_reset");
    step(0, 1, 0, 2, 0, "pre_reset");
    e0 = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (l0 != 2'd0 || s0 != 3'b000 || d0 != 1'b0) begin
      errors++;
      $display("FAIL async_reset: got level=%0d S=%b done=%b, want level=0 S=000 done=0",
               l0, s0, d0);
    end else begin
      $display("ok   async_reset level=%0d S=%b", l0, s0);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    step(0, 1, 0, 1, 0, "after_reset");

    // 6b: clear beats enter in the same cycle
    step(0, 1, 1, 0, 0, "clear_wins");
    step(0, 0, 0, 0, 0, "clear_idle");

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
